writeback_stage_v2: RTL and testbench

- Parametrised next-generation writeback stage of the RISC-V pipeline; sits between the memory stage and the register file write port.
- Accepts memory-stage results over a valid/ready handshake and buffers them through a one-entry skid buffer and a registered output stage.
- Formats load data (byte/half/word/dword, sign/zero extension); drives the register file write and a forwarding bus to execute.
- Absorbs write-port hold (`wb_hold`) without losing results.

---
 rtl/riscv_pkg.sv | 30 +++
 rtl/load_formatter.sv | 54 +++++
 rtl/writeback_stage_v2.sv | 151 +++++++++++++++
 tb/tb_writeback_stage_v2.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RISC-V pipeline definitions: load funct3 encodings and the
// writeback entry record carried through the writeback buffers.
package riscv_pkg;

    // Load size/sign encodings (funct3 field of the load opcode)
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LD  = 3'b011;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_LWU = 3'b110;

    // Entry fields are sized for the widest supported configuration
    // (RV64, up to 8-bit register addresses); narrower builds zero-pad.
    localparam int WB_DATA_W = 64;
    localparam int WB_RD_W   = 8;

    typedef struct packed {
        logic                 reg_write;
        logic [WB_RD_W-1:0]   rd;
        logic [WB_DATA_W-1:0] data;
    } wb_entry_t;

    // Width of the byte offset inside an aligned XLEN-wide memory word
    function automatic int load_off_w(input int xlen);
        return (xlen == 64) ? 3 : 2;
    endfunction

endpackage

// File: rtl/load_formatter.sv
// Combinational load-data formatter: selects the byte/half/word/dword
// addressed by 'off' inside the aligned memory word and sign- or
// zero-extends it to XLEN according to funct3.
module load_formatter
    import riscv_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int OFF_W = load_off_w(XLEN)
) (
    input  logic [2:0]       funct3,
    input  logic [OFF_W-1:0] off,
    input  logic [XLEN-1:0]  lmd,
    output logic [XLEN-1:0]  data
);

    logic [7:0]      byte_sel;
    logic [15:0]     half_sel;
    logic [XLEN-1:0] word_sx;
    logic [XLEN-1:0] word_zx;

    // Halfword selection ignores off[0]; misaligned halves fold down.
    assign byte_sel = lmd[{off, 3'b000} +: 8];
    assign half_sel = lmd[{off[OFF_W-1:1], 4'b0000} +: 16];

    generate
        if (XLEN == 64) begin : g_rv64
            logic [31:0] word_sel;
            assign word_sel = lmd[{off[2], 5'b00000} +: 32];
            assign word_sx  = {{32{word_sel[31]}}, word_sel};
            assign word_zx  = {32'd0, word_sel};
        end else begin : g_rv32
            // A word is the whole register on RV32; LWU is not defined
            // there and falls back to passing the raw data.
            assign word_sx = lmd;
            assign word_zx = lmd;
        end
    endgenerate

    // Extension selection by funct3
    always_comb begin
        data = lmd;
        case (funct3)
            F3_LB:   data = {{(XLEN-8){byte_sel[7]}}, byte_sel};
            F3_LBU:  data = {{(XLEN-8){1'b0}}, byte_sel};
            F3_LH:   data = {{(XLEN-16){half_sel[15]}}, half_sel};
            F3_LHU:  data = {{(XLEN-16){1'b0}}, half_sel};
            F3_LW:   data = word_sx;
            F3_LWU:  data = word_zx;
            F3_LD:   data = lmd;
            default: data = lmd;
        endcase
    end

endmodule

// File: rtl/writeback_stage_v2.sv
// Writeback stage: accepts memory-stage results over valid/ready, buffers
// them through a one-entry skid buffer and a registered output stage,
// formats load data, and drives the register-file write port plus a
// forwarding bus. The output register holds while wb_hold is asserted.
// Optional build macro WB_RETIRE_CNT_EN adds a 64-bit retire counter
// output (retire_count) counting every entry leaving the output register.
module writeback_stage_v2
    import riscv_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_reg_write,
    input  logic                  in_mem_to_reg,
    input  logic [2:0]            in_funct3,
    input  logic [REG_ADDR_W-1:0] in_rd_addr,
    input  logic [XLEN-1:0]       in_alu_result,
    input  logic [XLEN-1:0]       in_lmd,
    input  logic                  wb_hold,
    output logic                  rf_write_en,
    output logic [REG_ADDR_W-1:0] rf_rd_addr,
    output logic [XLEN-1:0]       rf_rd_data,
    output logic                  fwd_valid,
    output logic [REG_ADDR_W-1:0] fwd_rd_addr,
    output logic [XLEN-1:0]       fwd_data
`ifdef WB_RETIRE_CNT_EN
    ,
    output logic [63:0]           retire_count
`endif
);

    localparam int OFF_W = load_off_w(XLEN);

    logic [XLEN-1:0] fmt_data;
    logic [XLEN-1:0] in_data;
    wb_entry_t       in_entry;

    wb_entry_t skid_entry_reg, skid_entry_next;
    wb_entry_t out_entry_reg,  out_entry_next;
    logic      skid_valid_reg, skid_valid_next;
    logic      out_valid_reg,  out_valid_next;
    logic      in_ready_reg;

    logic accept;
    logic out_advance;
    logic rd_nonzero;
    logic out_live;
    logic unused_entry_bits;

    // Load data is formatted on the way in, so both buffers already hold
    // the final register value.
    load_formatter #(
        .XLEN (XLEN)
    ) u_load_formatter (
        .funct3 (in_funct3),
        .off    (in_alu_result[OFF_W-1:0]),
        .lmd    (in_lmd),
        .data   (fmt_data)
    );

    assign in_data = in_mem_to_reg ? fmt_data : in_alu_result;

    // Pack the incoming result into a (zero-padded) writeback entry
    always_comb begin
        in_entry           = '0;
        in_entry.reg_write = in_reg_write;
        in_entry.rd        = WB_RD_W'(in_rd_addr);
        in_entry.data      = WB_DATA_W'(in_data);
    end

    assign accept      = in_valid && in_ready_reg;
    assign out_advance = !out_valid_reg || !wb_hold;

    // Buffer steering: skid drains first; a new input lands in the skid
    // only while the output register is held. in_ready is low whenever
    // the skid is full, so skid-drain and accept never coincide.
    always_comb begin
        skid_valid_next = skid_valid_reg;
        skid_entry_next = skid_entry_reg;
        out_valid_next  = out_valid_reg;
        out_entry_next  = out_entry_reg;
        if (out_advance) begin
            if (skid_valid_reg) begin
                out_valid_next  = 1'b1;
                out_entry_next  = skid_entry_reg;
                skid_valid_next = 1'b0;
            end else if (accept) begin
                out_valid_next = 1'b1;
                out_entry_next = in_entry;
            end else begin
                out_valid_next = 1'b0;
            end
        end else if (accept) begin
            skid_valid_next = 1'b1;
            skid_entry_next = in_entry;
        end
    end

    // State registers; in_ready is registered from the next skid state so
    // wb_hold never reaches in_ready combinationally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            skid_valid_reg <= 1'b0;
            skid_entry_reg <= '0;
            out_valid_reg  <= 1'b0;
            out_entry_reg  <= '0;
            in_ready_reg   <= 1'b0;
        end else begin
            skid_valid_reg <= skid_valid_next;
            skid_entry_reg <= skid_entry_next;
            out_valid_reg  <= out_valid_next;
            out_entry_reg  <= out_entry_next;
            in_ready_reg   <= !skid_valid_next;
        end
    end

    // Writes to x0 are suppressed but the entry still retires.
    assign rd_nonzero = |out_entry_reg.rd[REG_ADDR_W-1:0];
    assign out_live   = out_valid_reg && out_entry_reg.reg_write && rd_nonzero;

    assign in_ready    = in_ready_reg;
    assign rf_write_en = out_live && !wb_hold;
    assign rf_rd_addr  = out_entry_reg.rd[REG_ADDR_W-1:0];
    assign rf_rd_data  = out_entry_reg.data[XLEN-1:0];
    assign fwd_valid   = out_live;
    assign fwd_rd_addr = out_entry_reg.rd[REG_ADDR_W-1:0];
    assign fwd_data    = out_entry_reg.data[XLEN-1:0];

    // Padding bits above XLEN / REG_ADDR_W are always zero and never read.
    assign unused_entry_bits = ^out_entry_reg;

`ifdef WB_RETIRE_CNT_EN
    logic [63:0] retire_count_reg;

    // Count every entry that leaves the output register (wraps at 2^64)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            retire_count_reg <= 64'd0;
        end else if (out_valid_reg && !wb_hold) begin
            retire_count_reg <= retire_count_reg + 64'd1;
        end
    end

    assign retire_count = retire_count_reg;
`endif

endmodule

// File: tb/tb_writeback_stage_v2.sv
// Self-checking bench for writeback_stage_v2: an RV32 and an RV64 instance
// share handshake stimulus; the RV32 instance is tracked by a queue-based
// reference model.
`timescale 1ns/1ps
module tb_writeback_stage_v2;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_reg_write, in_mem_to_reg, wb_hold;
    logic [2:0]  in_funct3;
    logic [4:0]  in_rd_addr;
    logic [31:0] alu32, lmd32;
    logic [63:0] alu64, lmd64;

    logic        in_ready32, we32, fv32;
    logic [4:0]  wa32, fa32;
    logic [31:0] wd32, fd32;
    logic        in_ready64, we64, fv64;
    logic [4:0]  wa64, fa64;
    logic [63:0] wd64, fd64;
`ifdef WB_RETIRE_CNT_EN
    logic [63:0] rc32, rc64;
`endif

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        bit          rw;
        logic [4:0]  rd;
        logic [31:0] data;
    } exp_t;

    exp_t            q[$];
    bit              m_ready;
    longint unsigned m_retired;

    localparam logic [2:0]  T32_F3  [7] = '{3'b000, 3'b000, 3'b101, 3'b001, 3'b010, 3'b100, 3'b101};
    localparam logic [1:0]  T32_OFF [7] = '{2'd0, 2'd3, 2'd2, 2'd3, 2'd0, 2'd1, 2'd0};
    localparam logic [31:0] T32_EXP [7] = '{32'h0000_0021, 32'hFFFF_FF87, 32'h0000_8765,
                                            32'hFFFF_8765, 32'h8765_4321, 32'h0000_0043,
                                            32'h0000_4321};
    localparam logic [2:0]  T64_F3  [7] = '{3'b010, 3'b110, 3'b011, 3'b000, 3'b101, 3'b010, 3'b001};
    localparam logic [2:0]  T64_OFF [7] = '{3'd0, 3'd0, 3'd0, 3'd3, 3'd6, 3'd4, 3'd1};
    localparam logic [63:0] T64_EXP [7] = '{64'hFFFF_FFFF_8000_0000, 64'h0000_0000_8000_0000,
                                            64'hFFFF_FFFF_8000_0000, 64'hFFFF_FFFF_FFFF_FF80,
                                            64'h0000_0000_0000_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
                                            64'h0000_0000_0000_0000};

    always #5 clk = ~clk;

    writeback_stage_v2 #(.XLEN(32), .REG_ADDR_W(5)) dut32 (
        .clk (clk), .rst (rst), .in_valid (in_valid), .in_ready (in_ready32),
        .in_reg_write (in_reg_write), .in_mem_to_reg (in_mem_to_reg),
        .in_funct3 (in_funct3), .in_rd_addr (in_rd_addr),
        .in_alu_result (alu32), .in_lmd (lmd32), .wb_hold (wb_hold),
        .rf_write_en (we32), .rf_rd_addr (wa32), .rf_rd_data (wd32),
        .fwd_valid (fv32), .fwd_rd_addr (fa32), .fwd_data (fd32)
`ifdef WB_RETIRE_CNT_EN
        , .retire_count (rc32)
`endif
    );

    writeback_stage_v2 #(.XLEN(64), .REG_ADDR_W(5)) dut64 (
        .clk (clk), .rst (rst), .in_valid (in_valid), .in_ready (in_ready64),
        .in_reg_write (in_reg_write), .in_mem_to_reg (in_mem_to_reg),
        .in_funct3 (in_funct3), .in_rd_addr (in_rd_addr),
        .in_alu_result (alu64), .in_lmd (lmd64), .wb_hold (wb_hold),
        .rf_write_en (we64), .rf_rd_addr (wa64), .rf_rd_data (wd64),
        .fwd_valid (fv64), .fwd_rd_addr (fa64), .fwd_data (fd64)
`ifdef WB_RETIRE_CNT_EN
        , .retire_count (rc64)
`endif
    );

    // Load formatting from the ISA rules, using plain arithmetic
    function automatic logic [63:0] ref_fmt(input int xlen, input logic [2:0] f3,
                                            input logic [63:0] addr, input logic [63:0] lmd);
        int          off, base;
        logic [63:0] v;
        off = (xlen == 64) ? int'(addr % 8) : int'(addr % 4);
        case (f3)
            3'b000, 3'b100: begin
                v = (lmd >> (8 * off)) % 256;
                if (f3 == 3'b000 && v >= 128) v = v - 256;
            end
            3'b001, 3'b101: begin
                base = off - (off % 2);
                v = (lmd >> (8 * base)) % 65536;
                if (f3 == 3'b001 && v >= 32768) v = v - 65536;
            end
            3'b010, 3'b110: begin
                if (xlen == 64) begin
                    base = off - (off % 4);
                    v = (lmd >> (8 * base)) % 64'h1_0000_0000;
                    if (f3 == 3'b010 && v >= 64'h8000_0000) v = v - 64'h1_0000_0000;
                end else begin
                    v = lmd;
                end
            end
            default: v = lmd;
        endcase
        if (xlen == 32) v = v % 64'h1_0000_0000;
        return v;
    endfunction

    task automatic drive(input logic v, input logic rw, input logic m2r, input logic [2:0] f3,
                         input logic [4:0] rd, input logic [31:0] a32, input logic [31:0] l32,
                         input logic [63:0] a64, input logic [63:0] l64);
        in_valid      = v;
        in_reg_write  = rw;
        in_mem_to_reg = m2r;
        in_funct3     = f3;
        in_rd_addr    = rd;
        alu32         = a32;
        lmd32         = l32;
        alu64         = a64;
        lmd64         = l64;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, 3'b000, 5'd0, 32'd0, 32'd0, 64'd0, 64'd0);
    endtask

    // One clock edge: model transfer/retire decided from the pre-edge inputs
    task automatic cycle();
        exp_t        e;
        bit          acc, ret;
        logic [63:0] f;
        acc    = in_valid && m_ready;
        ret    = (q.size() > 0) && !wb_hold;
        f      = ref_fmt(32, in_funct3, {32'd0, alu32}, {32'd0, lmd32});
        e.rw   = in_reg_write;
        e.rd   = in_rd_addr;
        e.data = in_mem_to_reg ? f[31:0] : alu32;
        @(posedge clk);
        if (ret) begin
            void'(q.pop_front());
            m_retired++;
        end
        if (acc) q.push_back(e);
        m_ready = (q.size() < 2);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        wb_hold = 1'b0;
        idle();
        q.delete();
        m_ready = 1'b0;
        m_retired = 0;
        repeat (2) @(posedge clk);
        #1;
        n_vec++; if (in_ready32 !== 1'b0) begin n_err++; $display("FAIL reset_in_ready got %b want 0", in_ready32); end
        n_vec++; if (we32 !== 1'b0) begin n_err++; $display("FAIL reset_we got %b want 0", we32); end
        n_vec++; if (fv32 !== 1'b0) begin n_err++; $display("FAIL reset_fwd_valid got %b want 0", fv32); end
        n_vec++; if (wd32 !== 32'd0 || wa32 !== 5'd0) begin n_err++; $display("FAIL reset_rf_out got %h/%h want 0/0", wa32, wd32); end
        n_vec++; if (fd32 !== 32'd0 || fa32 !== 5'd0) begin n_err++; $display("FAIL reset_fwd_out got %h/%h want 0/0", fa32, fd32); end
`ifdef WB_RETIRE_CNT_EN
        n_vec++; if (rc32 !== 64'd0) begin n_err++; $display("FAIL reset_retire got %0d want 0", rc32); end
`endif
        rst = 1'b0;
        cycle();
        n_vec++; if (in_ready32 !== 1'b1 || in_ready64 !== 1'b1) begin n_err++; $display("FAIL reset_ready_after got %b%b want 11", in_ready32, in_ready64); end
    endtask

    task automatic test_alu_path();
        drive(1'b1, 1'b1, 1'b0, 3'b010, 5'd1, 32'h1234_5678, 32'h0, 64'h0, 64'h0);
        cycle();
        idle();
        #1;
        n_vec++; if (we32 !== 1'b1) begin n_err++; $display("FAIL alu_we got %b want 1", we32); end
        n_vec++; if (wa32 !== 5'd1) begin n_err++; $display("FAIL alu_addr got %0d want 1", wa32); end
        n_vec++; if (wd32 !== 32'h1234_5678) begin n_err++; $display("FAIL alu_data got %h want 12345678", wd32); end
        n_vec++; if (fv32 !== 1'b1 || fd32 !== 32'h1234_5678) begin n_err++; $display("FAIL alu_fwd got %b/%h want 1/12345678", fv32, fd32); end
        cycle();
        n_vec++; if (we32 !== 1'b0) begin n_err++; $display("FAIL alu_retired got we=%b want 0", we32); end
    endtask

    task automatic test_load_fmt32();
        for (int i = 0; i < 7; i++) begin
            drive(1'b1, 1'b1, 1'b1, T32_F3[i], 5'd7, 32'h0000_1000 | 32'(T32_OFF[i]),
                  32'h8765_4321, 64'h0, 64'h0);
            cycle();
            idle();
            #1;
            n_vec++;
            if (we32 !== 1'b1 || wd32 !== T32_EXP[i]) begin
                n_err++;
                $display("FAIL fmt32[%0d] f3=%b off=%0d got we=%b data=%h want we=1 data=%h",
                         i, T32_F3[i], T32_OFF[i], we32, wd32, T32_EXP[i]);
            end
            cycle();
        end
    endtask

    task automatic test_load_fmt64();
        for (int i = 0; i < 7; i++) begin
            drive(1'b1, 1'b1, 1'b1, T64_F3[i], 5'd9, 32'h0, 32'h0,
                  64'h0000_2000 | 64'(T64_OFF[i]), 64'hFFFF_FFFF_8000_0000);
            cycle();
            idle();
            #1;
            n_vec++;
            if (we64 !== 1'b1 || wd64 !== T64_EXP[i]) begin
                n_err++;
                $display("FAIL fmt64[%0d] f3=%b off=%0d got we=%b data=%h want we=1 data=%h",
                         i, T64_F3[i], T64_OFF[i], we64, wd64, T64_EXP[i]);
            end
            cycle();
        end
    endtask

    task automatic test_x0();
        drive(1'b1, 1'b1, 1'b0, 3'b000, 5'd0, 32'hDEAD_BEEF, 32'h0, 64'h0, 64'h0);
        cycle();
        idle();
        #1;
        n_vec++; if (we32 !== 1'b0) begin n_err++; $display("FAIL x0_we got %b want 0", we32); end
        n_vec++; if (fv32 !== 1'b0) begin n_err++; $display("FAIL x0_fwd_valid got %b want 0", fv32); end
        cycle();
`ifdef WB_RETIRE_CNT_EN
        n_vec++; if (rc32 !== 64'(m_retired)) begin n_err++; $display("FAIL x0_retire got %0d want %0d", rc32, m_retired); end
`endif
        n_vec++; if (in_ready32 !== 1'b1) begin n_err++; $display("FAIL x0_ready got %b want 1", in_ready32); end
    endtask

    task automatic test_hold_skid();
        wb_hold = 1'b1;
        drive(1'b1, 1'b1, 1'b0, 3'b000, 5'd2, 32'hA, 32'h0, 64'h0, 64'h0);
        cycle();
        drive(1'b1, 1'b1, 1'b0, 3'b000, 5'd3, 32'hB, 32'h0, 64'h0, 64'h0);
        #1;
        n_vec++; if (we32 !== 1'b0) begin n_err++; $display("FAIL hold_we1 got %b want 0", we32); end
        n_vec++; if (fv32 !== 1'b1 || fa32 !== 5'd2 || fd32 !== 32'hA) begin n_err++; $display("FAIL hold_fwd got %b/%0d/%h want 1/2/a", fv32, fa32, fd32); end
        n_vec++; if (in_ready32 !== 1'b1) begin n_err++; $display("FAIL hold_ready1 got %b want 1", in_ready32); end
        cycle();
        idle();
        #1;
        n_vec++; if (in_ready32 !== 1'b0) begin n_err++; $display("FAIL skid_full_ready got %b want 0", in_ready32); end
        n_vec++; if (we32 !== 1'b0) begin n_err++; $display("FAIL hold_we2 got %b want 0", we32); end
        cycle();
        wb_hold = 1'b0;
        #1;
        n_vec++; if (we32 !== 1'b1 || wa32 !== 5'd2 || wd32 !== 32'hA) begin n_err++; $display("FAIL release_first got %b/%0d/%h want 1/2/a", we32, wa32, wd32); end
        n_vec++; if (in_ready32 !== 1'b0) begin n_err++; $display("FAIL release_ready0 got %b want 0", in_ready32); end
        cycle();
        n_vec++; if (we32 !== 1'b1 || wa32 !== 5'd3 || wd32 !== 32'hB) begin n_err++; $display("FAIL release_second got %b/%0d/%h want 1/3/b", we32, wa32, wd32); end
        n_vec++; if (in_ready32 !== 1'b1) begin n_err++; $display("FAIL release_ready1 got %b want 1", in_ready32); end
        cycle();
        n_vec++; if (we32 !== 1'b0 || fv32 !== 1'b0) begin n_err++; $display("FAIL no_dup got %b/%b want 0/0", we32, fv32); end
    endtask

    task automatic test_reset_mid();
        wb_hold = 1'b1;
        drive(1'b1, 1'b1, 1'b0, 3'b000, 5'd4, 32'h44, 32'h0, 64'h0, 64'h0);
        cycle();
        drive(1'b1, 1'b1, 1'b0, 3'b000, 5'd5, 32'h55, 32'h0, 64'h0, 64'h0);
        cycle();
        idle();
        #1;
        n_vec++; if (in_ready32 !== 1'b0 || fv32 !== 1'b1) begin n_err++; $display("FAIL rstmid_buffered got ready=%b fwd=%b want 0/1", in_ready32, fv32); end
        rst = 1'b1;
        wb_hold = 1'b0;
        q.delete();
        m_ready = 1'b0;
        m_retired = 0;
        #1;
        n_vec++; if (we32 !== 1'b0 || fv32 !== 1'b0) begin n_err++; $display("FAIL rstmid_async got we=%b fwd=%b want 0/0", we32, fv32); end
        @(posedge clk);
        #2;
        rst = 1'b0;
        n_vec++; if (in_ready32 !== 1'b0) begin n_err++; $display("FAIL rstmid_ready_in_rst got %b want 0", in_ready32); end
        cycle();
        n_vec++; if (in_ready32 !== 1'b1) begin n_err++; $display("FAIL rstmid_ready got %b want 1", in_ready32); end
        for (int i = 0; i < 3; i++) begin
            n_vec++; if (we32 !== 1'b0 || fv32 !== 1'b0) begin n_err++; $display("FAIL rstmid_nowrite[%0d] got we=%b fwd=%b want 0/0", i, we32, fv32); end
            cycle();
        end
    endtask

    task automatic test_random();
        exp_t h;
        bit   e_live;
        for (int i = 0; i < 400; i++) begin
            drive(($urandom % 4) != 0, ($urandom % 5) != 0, $urandom % 2, 3'($urandom % 8),
                  (($urandom % 8) == 0) ? 5'd0 : 5'($urandom % 32), $urandom, $urandom,
                  {$urandom, $urandom}, {$urandom, $urandom});
            wb_hold = (i < 380) && (($urandom % 10) < 3);
            #1;
            e_live = 1'b0;
            if (q.size() > 0) begin
                h = q[0];
                e_live = h.rw && (h.rd != 5'd0);
            end
            n_vec++;
            if (in_ready32 !== m_ready || fv32 !== e_live || we32 !== (e_live && !wb_hold)) begin
                n_err++;
                $display("FAIL rand[%0d] ctrl got ready=%b fwd=%b we=%b want ready=%b fwd=%b we=%b",
                         i, in_ready32, fv32, we32, m_ready, e_live, e_live && !wb_hold);
            end
            if (e_live) begin
                n_vec++;
                if (wa32 !== h.rd || wd32 !== h.data || fd32 !== h.data || fa32 !== h.rd) begin
                    n_err++;
                    $display("FAIL rand[%0d] data got rd=%0d data=%h want rd=%0d data=%h",
                             i, wa32, wd32, h.rd, h.data);
                end
            end
`ifdef WB_RETIRE_CNT_EN
            n_vec++;
            if (rc32 !== 64'(m_retired)) begin
                n_err++;
                $display("FAIL rand[%0d] retire got %0d want %0d", i, rc32, m_retired);
            end
`endif
            cycle();
        end
        idle();
        wb_hold = 1'b0;
        repeat (3) cycle();
        n_vec++; if (q.size() != 0 || we32 !== 1'b0 || in_ready32 !== 1'b1) begin n_err++; $display("FAIL rand_drain got we=%b ready=%b want 0/1", we32, in_ready32); end
    endtask

    initial begin
        test_reset();
        test_alu_path();
        test_load_fmt32();
        test_x0();
        test_hold_skid();
        test_reset_mid();
        test_load_fmt64();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
